uart_fifo_controller: RTL and testbench
=======================================

// Module: uart_fifo_controller
// PURPOSE
//  Parametrised UART core for the next generation of the UART controller. Provides a full-duplex TX/RX pair
//  with runtime-selectable internal loopback, configurable frame format (data bits, parity, stop bits) and
//  TX/RX FIFOs with valid/ready handshakes. Runs entirely on one clock with baud/oversample enable ticks.
//  There are no derived clocks. Sits between the system-side byte interface and the serial pins.
// PARAMETERS
//  CLOCK_RATE    25000000  system clock frequency, Hz
//  BAUD_RATE     9600      serial bit rate
//  RX_OVERSAMPLE 16        enable ticks per bit; even, >=8
//  DATA_BITS     8         data bits per frame, 5..9
//  PARITY        0         0 = none, 1 = even, 2 = odd
//  STOP_BITS     1         1 or 2
//  FIFO_DEPTH    16        entries per FIFO; power of 2, >=2
// PORTS
//  clk             in   1          system clock, rising edge
//  reset           in   1          asynchronous, active-high reset
//  i_Tx_Byte       in   DATA_BITS  TX data
//  i_Tx_Valid      in   1          push request into TX FIFO
//  o_Tx_Ready      out  1          TX FIFO not full; push occurs when Valid && Ready
//  o_Rx_Byte       out  DATA_BITS  head of RX FIFO
//  o_Rx_Parity_Err out  1          parity error flag travelling with o_Rx_Byte
//  o_Rx_Frame_Err  out  1          stop-bit error flag travelling with o_Rx_Byte
//  o_Rx_Valid      out  1          RX FIFO not empty
//  i_Rx_Ready      in   1          pop; an entry is consumed when Valid && Ready
//  o_Rx_Overrun    out  1          sticky: a received frame was dropped because the RX FIFO was full
//  i_Err_Clr       in   1          clears o_Rx_Overrun (set takes priority on the same cycle)
//  i_Loopback      in   1          1 = RX input taken from internal TX line
//  i_Rx_Data       in   1          serial input pin, asynchronous
//  o_Tx_Data       out  1          serial output pin; idle high
//  o_Tx_Active     out  1          TX shifter busy (start..last stop)
// BEHAVIOUR
//  Reset: o_Tx_Data=1; o_Tx_Active, o_Rx_Valid, o_Rx_Overrun and the error flags = 0; o_Tx_Ready=1.
//   Both FIFOs are emptied. Reset mid-frame aborts the frame immediately and the line returns high.
//  Tick gen: counter of DIV = CLOCK_RATE/(BAUD_RATE*RX_OVERSAMPLE), integer truncated, min 1.
//   Emits a 1-clk tick on wrap. One bit = RX_OVERSAMPLE ticks.
//  TX FSM IDLE->START->DATA->PARITY (if PARITY!=0)->STOP (STOP_BITS bits)->IDLE:
//   - IDLE pops the FIFO when it is non-empty. o_Tx_Data falls on the clk after the pop.
//   - Data is sent LSB first. Parity is computed over the data bits: even gives an even count of ones, odd an odd count.
//   - Back-to-back frames have no idle gap. The first bit may be short by <1 tick.
//  RX path: i_Rx_Data passes through a 2-FF synchroniser. The loopback mux sits after the synchroniser;
//   the mux select is latched only while RX is IDLE.
//  RX FSM IDLE->START->DATA->PARITY->STOP->IDLE:
//   - A falling edge starts the tick count; the start bit is re-checked at tick RX_OVERSAMPLE/2.
//   - If the line is high at that check, the start is treated as a glitch and the FSM returns to IDLE.
//   - Every later bit is sampled at the centre tick.
//   - Only the first stop bit is checked; 0 sets the frame error.
//   - At the first stop-bit sample the FSM pushes {frame_err, parity_err, byte} and returns to IDLE (hunts immediately).
//   - If the RX FIFO is full, the frame is dropped and o_Rx_Overrun is set.
//  FIFOs: synchronous, with pointers of log2(DEPTH)+1 bits (extra bit is the wrap bit). Full = MSBs differ and low bits match.
//   - Push while full is ignored; pop while empty is ignored.
//   - Push and pop on the same cycle: both take effect when neither the full nor the empty guard blocks them.
//   - The RX head is visible on the outputs with 0 latency (registered memory with first-word fall-through).
//  Capacity: the TX path accepts FIFO_DEPTH bytes plus 1 held in the shifter.
// STRUCTURE
//  Shared package uart_pkg:
//   - parity encodings PAR_NONE/PAR_EVEN/PAR_ODD;
//   - TX/RX state enums;
//   - function clog2;
//   - function parity(data, mode).
//  Sub-module uart_sync_fifo #(WIDTH,DEPTH), instanced for TX (WIDTH=DATA_BITS) and RX (WIDTH=DATA_BITS+2).
//  Tick generator, TX FSM and RX FSM are inline.
// TESTING (CLOCK_RATE=1600000, BAUD_RATE=100000, OVERSAMPLE=16 -> tick every clk, bit = 16 clk)
//  1. 8N1, loopback=1, push 0xA5 -> o_Tx_Data = 0,1,0,1,0,0,1,0,1,1, each for 16 clk.
//     Then o_Rx_Valid=1, o_Rx_Byte=0xA5, both error flags 0.
//  2. PARITY=1, push 0x07 -> parity bit = 1. External 8E1 frame 0x07 with parity 0 -> byte 0x07 with o_Rx_Parity_Err=1.
//  3. External frame 0x3C with stop bit 0 -> o_Rx_Frame_Err=1.
//     A following 4-clk low glitch on the idle line -> no RX push.
//  4. FIFO_DEPTH=16, TX idle, 18 back-to-back pushes -> o_Tx_Ready low after the 17th is accepted.
//     All 17 bytes are transmitted in order with no gaps; o_Tx_Active falls after the final stop bit.
//  5. i_Rx_Ready=0, loopback 17 frames -> 16 are stored, o_Rx_Overrun=1, and the 17th is dropped.
//     i_Err_Clr clears the flag; draining returns bytes 1..16.
//  6. Assert reset at tick 40 of a TX frame -> o_Tx_Data=1 and the FIFOs are empty in the same cycle.
//     After release, a new push transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: parity encodings, FSM state types
// and small constant/helper functions used by the top level and the FIFOs.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Parity bit for up to 9 data bits (unused upper bits must be zero).
    function automatic logic parity(input logic [8:0] data, input logic [1:0] mode);
        logic ones;
        ones = ^data;
        case (mode)
            PAR_EVEN: return ones;
            PAR_ODD:  return ~ones;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and first-word fall-through read:
// rd_data always shows the entry at the read pointer while not empty.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; blocked push/pop simply leave their pointer alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_fifo_controller.sv
// Full-duplex UART with TX/RX FIFOs, configurable frame format and internal
// loopback. All timing derives from a single oversample enable tick.
module uart_fifo_controller
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE    = 25000000,
    parameter int BAUD_RATE     = 9600,
    parameter int RX_OVERSAMPLE = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    input  logic                 i_Tx_Valid,
    output logic                 o_Tx_Ready,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_Parity_Err,
    output logic                 o_Rx_Frame_Err,
    output logic                 o_Rx_Valid,
    input  logic                 i_Rx_Ready,
    output logic                 o_Rx_Overrun,
    input  logic                 i_Err_Clr,
    input  logic                 i_Loopback,
    input  logic                 i_Rx_Data,
    output logic                 o_Tx_Data,
    output logic                 o_Tx_Active
);

    localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = clog2(DIV + 1);
    localparam int CNT_W   = clog2(RX_OVERSAMPLE);
    localparam int RXW     = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RX_OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(RX_OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [1:0]       PAR_MODE  = 2'(PARITY);

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    // Free-running divider emitting one enable tick per wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // ---------------- TX path ----------------
    tx_state_t            tx_state, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt, tx_cnt_d;
    logic [3:0]           tx_bit, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
    logic                 tx_par, tx_par_d;
    logic                 tx_line, tx_line_d;
    logic                 tx_end, tx_load, tx_pop;
    logic                 tx_full, tx_empty;
    logic [DATA_BITS-1:0] tx_head;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (i_Tx_Valid),
        .wr_data (i_Tx_Byte),
        .full    (tx_full),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .empty   (tx_empty)
    );

    assign tx_end = tick && (tx_cnt == CNT_FULL);

    // TX next-state: bit sequencing, and a FIFO pop whenever a new frame is loaded
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_par_d   = tx_par;
        tx_line_d  = tx_line;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        if (tick && tx_state != TX_IDLE) tx_cnt_d = tx_end ? '0 : tx_cnt + 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                tx_load   = !tx_empty;
            end
            TX_START: begin
                if (tx_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_end) begin
                    if (tx_bit == BIT_LAST) begin
                        tx_bit_d = '0;
                        if (PARITY != 0) begin
                            tx_state_d = TX_PARITY;
                            tx_line_d  = tx_par;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_line_d  = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit + 1'b1;
                        tx_shift_d = tx_shift >> 1;
                        tx_line_d  = tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_end) begin
                    tx_state_d = TX_STOP;
                    tx_line_d  = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_end) begin
                    if (tx_bit == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                        tx_load    = !tx_empty;
                    end else begin
                        tx_bit_d = tx_bit + 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Loading straight from STOP keeps back-to-back frames gap-free
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_head;
            tx_par_d   = parity(9'(tx_head), PAR_MODE);
            tx_line_d  = 1'b0;
        end
    end

    // TX control registers; reset drives the line high immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_line  <= tx_line_d;
        end
    end

    // TX data registers (shift value and precomputed parity)
    always_ff @(posedge clk) begin
        tx_shift <= tx_shift_d;
        tx_par   <= tx_par_d;
    end

    assign o_Tx_Data   = tx_line;
    assign o_Tx_Active = (tx_state != TX_IDLE);
    assign o_Tx_Ready  = !tx_full;

    // ---------------- RX path ----------------
    rx_state_t            rx_state, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt, rx_cnt_d;
    logic [3:0]           rx_bit, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
    logic                 rx_perr, rx_perr_d;
    logic [1:0]           rx_sync;
    logic                 lb_sel, rx_line, rx_prev, rx_mid, rx_push;
    logic                 rx_full, rx_empty;
    logic [RXW-1:0]       rx_push_data, rx_head;

    assign rx_line      = lb_sel ? tx_line : rx_sync[1];
    assign rx_mid       = tick && (rx_cnt == CNT_FULL);
    assign rx_push_data = {~rx_line, rx_perr, rx_shift};

    // Pin synchroniser, loopback select (frozen while a frame is in progress), edge history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync <= 2'b11;
            lb_sel  <= 1'b0;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], i_Rx_Data};
            if (rx_state == RX_IDLE) lb_sel <= i_Loopback;
            rx_prev <= rx_line;
        end
    end

    // RX next-state: start qualification at half bit, then centre sampling
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_perr_d  = rx_perr;
        rx_push    = 1'b0;
        if (tick && rx_state != RX_IDLE) rx_cnt_d = rx_mid ? '0 : rx_cnt + 1'b1;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev && !rx_line) rx_state_d = RX_START;
            end
            RX_START: begin
                if (tick && rx_cnt == CNT_HALF) begin
                    rx_cnt_d = '0;
                    if (rx_line) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = '0;
                        rx_perr_d  = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_mid) begin
                    rx_shift_d = {rx_line, rx_shift[DATA_BITS-1:1]};
                    if (rx_bit == BIT_LAST) rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
                    else                    rx_bit_d   = rx_bit + 1'b1;
                end
            end
            RX_PARITY: begin
                if (rx_mid) begin
                    rx_perr_d  = rx_line ^ parity(9'(rx_shift), PAR_MODE);
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_mid) begin
                    rx_push    = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
        end
    end

    // RX data registers (assembled byte and its parity flag)
    always_ff @(posedge clk) begin
        rx_shift <= rx_shift_d;
        rx_perr  <= rx_perr_d;
    end

    // Sticky overrun; a new drop wins over a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   o_Rx_Overrun <= 1'b0;
        else if (rx_push && rx_full) o_Rx_Overrun <= 1'b1;
        else if (i_Err_Clr)          o_Rx_Overrun <= 1'b0;
    end

    uart_sync_fifo #(.WIDTH(RXW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_push),
        .wr_data (rx_push_data),
        .full    (rx_full),
        .rd_en   (i_Rx_Ready),
        .rd_data (rx_head),
        .empty   (rx_empty)
    );

    assign o_Rx_Valid = !rx_empty;
    assign {o_Rx_Frame_Err, o_Rx_Parity_Err, o_Rx_Byte} = rx_empty ? '0 : rx_head;

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed bench for uart_fifo_controller: an 8N1 instance and an 8E1
// instance share clock, reset and the external serial pin.
module tb_uart_fifo_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic rx_pin;

    logic [7:0] n_tx_byte, n_rx_byte;
    logic n_tx_valid, n_tx_ready, n_perr, n_ferr, n_rx_valid, n_rx_ready;
    logic n_ovr, n_err_clr, n_lb, n_tx_data, n_tx_active;

    logic [7:0] e_tx_byte, e_rx_byte;
    logic e_tx_valid, e_tx_ready, e_perr, e_ferr, e_rx_valid, e_rx_ready;
    logic e_ovr, e_err_clr, e_lb, e_tx_data, e_tx_active;

    uart_fifo_controller #(
        .CLOCK_RATE(1600000), .BAUD_RATE(100000), .RX_OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut_n (
        .clk(clk), .reset(reset),
        .i_Tx_Byte(n_tx_byte), .i_Tx_Valid(n_tx_valid), .o_Tx_Ready(n_tx_ready),
        .o_Rx_Byte(n_rx_byte), .o_Rx_Parity_Err(n_perr), .o_Rx_Frame_Err(n_ferr),
        .o_Rx_Valid(n_rx_valid), .i_Rx_Ready(n_rx_ready), .o_Rx_Overrun(n_ovr),
        .i_Err_Clr(n_err_clr), .i_Loopback(n_lb), .i_Rx_Data(rx_pin),
        .o_Tx_Data(n_tx_data), .o_Tx_Active(n_tx_active)
    );

    uart_fifo_controller #(
        .CLOCK_RATE(1600000), .BAUD_RATE(100000), .RX_OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut_e (
        .clk(clk), .reset(reset),
        .i_Tx_Byte(e_tx_byte), .i_Tx_Valid(e_tx_valid), .o_Tx_Ready(e_tx_ready),
        .o_Rx_Byte(e_rx_byte), .o_Rx_Parity_Err(e_perr), .o_Rx_Frame_Err(e_ferr),
        .o_Rx_Valid(e_rx_valid), .i_Rx_Ready(e_rx_ready), .o_Rx_Overrun(e_ovr),
        .i_Err_Clr(e_err_clr), .i_Loopback(e_lb), .i_Rx_Data(rx_pin),
        .o_Tx_Data(e_tx_data), .o_Tx_Active(e_tx_active)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // bit i = i-th serial bit (start, d0..d7, stop)
        logic [7:0] rx;
    } vec_t;
    vec_t vecs [5];

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_n(input logic [7:0] b);
        n_tx_byte  = b;
        n_tx_valid = 1'b1;
        step();
        n_tx_valid = 1'b0;
    endtask

    task automatic wait_n_fall(input string name);
        int t = 0;
        while (n_tx_data !== 1'b0 && t < 400) begin
            step();
            t++;
        end
        chk($sformatf("%s start", name), 32'(n_tx_data), 0);
    endtask

    // Checks every bit at its first and last clock of the 16-clock bit time
    task automatic tx_frame_check(input logic [9:0] exp, input string name);
        wait_n_fall(name);
        step(15);
        chk($sformatf("%s bit0 end", name), 32'(n_tx_data), 32'(exp[0]));
        step(1);
        for (int i = 1; i < 10; i++) begin
            chk($sformatf("%s bit%0d begin", name, i), 32'(n_tx_data), 32'(exp[i]));
            step(15);
            chk($sformatf("%s bit%0d end", name, i), 32'(n_tx_data), 32'(exp[i]));
            step(1);
        end
    endtask

    task automatic rx_wait_n(input logic [7:0] b, input int pe, input int fe, input string name);
        int t = 0;
        while (n_rx_valid !== 1'b1 && t < 400) begin
            step();
            t++;
        end
        chk($sformatf("%s rx_valid", name), 32'(n_rx_valid), 1);
        chk($sformatf("%s rx_byte", name), 32'(n_rx_byte), 32'(b));
        chk($sformatf("%s parity_err", name), 32'(n_perr), 32'(pe));
        chk($sformatf("%s frame_err", name), 32'(n_ferr), 32'(fe));
        n_rx_ready = 1'b1;
        step();
        n_rx_ready = 1'b0;
    endtask

    task automatic rx_wait_e(input logic [7:0] b, input int pe, input int fe, input string name);
        int t = 0;
        while (e_rx_valid !== 1'b1 && t < 400) begin
            step();
            t++;
        end
        chk($sformatf("%s rx_valid", name), 32'(e_rx_valid), 1);
        chk($sformatf("%s rx_byte", name), 32'(e_rx_byte), 32'(b));
        chk($sformatf("%s parity_err", name), 32'(e_perr), 32'(pe));
        chk($sformatf("%s frame_err", name), 32'(e_ferr), 32'(fe));
        e_rx_ready = 1'b1;
        step();
        e_rx_ready = 1'b0;
    endtask

    // Drives n bits LSB first onto the external pin, 16 clocks each
    task automatic send_bits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_pin = bits[i];
            step(16);
        end
        rx_pin = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 10'b1101001010, 8'hA5};
        vecs[1] = '{8'h3C, 10'b1001111000, 8'h3C};
        vecs[2] = '{8'h00, 10'b1000000000, 8'h00};
        vecs[3] = '{8'hFF, 10'b1111111110, 8'hFF};
        vecs[4] = '{8'h01, 10'b1000000010, 8'h01};

        reset = 1'b1;
        rx_pin = 1'b1;
        n_tx_byte = '0; n_tx_valid = 1'b0; n_rx_ready = 1'b0; n_err_clr = 1'b0; n_lb = 1'b1;
        e_tx_byte = '0; e_tx_valid = 1'b0; e_rx_ready = 1'b0; e_err_clr = 1'b0; e_lb = 1'b1;
        step(3);

        // Reset state
        chk("reset tx_data", 32'(n_tx_data), 1);
        chk("reset tx_active", 32'(n_tx_active), 0);
        chk("reset tx_ready", 32'(n_tx_ready), 1);
        chk("reset rx_valid", 32'(n_rx_valid), 0);
        chk("reset overrun", 32'(n_ovr), 0);
        chk("reset parity_err", 32'(n_perr), 0);
        chk("reset frame_err", 32'(n_ferr), 0);
        reset = 1'b0;
        step(2);

        // 8N1 loopback frames from the vector table
        for (int v = 0; v < 5; v++) begin
            push_n(vecs[v].data);
            tx_frame_check(vecs[v].frame, $sformatf("vec%0d", v));
            rx_wait_n(vecs[v].rx, 0, 0, $sformatf("vec%0d", v));
        end

        // 8E1: transmitted parity bit, loopback receive, then external bad-parity frame
        begin
            int t = 0;
            e_tx_byte  = 8'h07;
            e_tx_valid = 1'b1;
            step();
            e_tx_valid = 1'b0;
            while (e_tx_data !== 1'b0 && t < 400) begin
                step();
                t++;
            end
            chk("even start", 32'(e_tx_data), 0);
            step(136);
            chk("even data bit7", 32'(e_tx_data), 0);
            step(16);
            chk("even parity bit", 32'(e_tx_data), 1);
            step(16);
            chk("even stop bit", 32'(e_tx_data), 1);
            step(16);
            chk("even tx_active after frame", 32'(e_tx_active), 0);
            rx_wait_e(8'h07, 0, 0, "even loopback");
        end
        e_lb = 1'b0;
        step(4);
        send_bits(12'h40E, 11);
        rx_wait_e(8'h07, 1, 0, "even bad parity");
        e_lb = 1'b1;

        // Frame error on external 8N1 frame, then a short glitch must not start a frame
        n_lb = 1'b0;
        step(4);
        send_bits(12'h078, 10);
        rx_wait_n(8'h3C, 0, 1, "frame error");
        step(32);
        rx_pin = 1'b0;
        step(4);
        rx_pin = 1'b1;
        step(200);
        chk("glitch no push", 32'(n_rx_valid), 0);
        n_lb = 1'b1;
        step(4);

        // 18 back-to-back pushes into an idle TX; RX not drained so the 17th frame overruns
        n_rx_ready = 1'b0;
        fork
            begin : pusher
                for (int k = 1; k <= 18; k++) begin
                    n_tx_byte  = 8'(k);
                    n_tx_valid = 1'b1;
                    chk($sformatf("burst ready before push %0d", k), 32'(n_tx_ready), (k <= 17) ? 1 : 0);
                    step();
                end
                n_tx_valid = 1'b0;
            end
            begin : monitor
                logic [9:0] fr;
                wait_n_fall("burst");
                step(8);
                chk("burst tx_active", 32'(n_tx_active), 1);
                for (int f = 0; f < 17; f++) begin
                    fr = {1'b1, 8'(f + 1), 1'b0};
                    for (int i = 0; i < 10; i++) begin
                        chk($sformatf("burst frame%0d bit%0d", f + 1, i), 32'(n_tx_data), 32'(fr[i]));
                        step(16);
                    end
                end
                chk("burst tx_active after last stop", 32'(n_tx_active), 0);
                chk("burst line idle", 32'(n_tx_data), 1);
            end
        join
        chk("overrun set", 32'(n_ovr), 1);
        n_err_clr = 1'b1;
        step();
        n_err_clr = 1'b0;
        chk("overrun cleared", 32'(n_ovr), 0);
        for (int j = 1; j <= 16; j++) begin
            chk($sformatf("drain%0d valid", j), 32'(n_rx_valid), 1);
            chk($sformatf("drain%0d byte", j), 32'(n_rx_byte), j);
            chk($sformatf("drain%0d errs", j), 32'({n_ferr, n_perr}), 0);
            n_rx_ready = 1'b1;
            step();
            n_rx_ready = 1'b0;
        end
        chk("drain 17th dropped", 32'(n_rx_valid), 0);

        // Reset 40 clocks into a frame with one byte queued and one RX entry held
        push_n(8'h11);
        tx_frame_check(10'b1000100010, "pre-reset");
        begin
            int t = 0;
            while (n_rx_valid !== 1'b1 && t < 400) begin
                step();
                t++;
            end
            chk("pre-reset rx held", 32'(n_rx_valid), 1);
        end
        push_n(8'h22);
        push_n(8'h33);
        wait_n_fall("reset frame");
        step(40);
        reset = 1'b1;
        #1;
        chk("mid-frame reset tx_data", 32'(n_tx_data), 1);
        chk("mid-frame reset tx_active", 32'(n_tx_active), 0);
        chk("mid-frame reset rx_valid", 32'(n_rx_valid), 0);
        chk("mid-frame reset tx_ready", 32'(n_tx_ready), 1);
        step(2);
        reset = 1'b0;
        step(4);
        chk("post-reset tx fifo empty", 32'(n_tx_active), 0);
        push_n(8'h5A);
        tx_frame_check(10'b1010110100, "post-reset");
        rx_wait_n(8'h5A, 0, 0, "post-reset");
        step(50);
        chk("post-reset no extra tx", 32'(n_tx_active), 0);
        chk("post-reset no extra rx", 32'(n_rx_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
